// File: rtl/ipml_fifo_fwft_rd_stage_pkg.sv
// Shared constants and elaboration helpers for the FWFT read stage.
// Holds the legal read-latency range and buffer geometry checks.
package ipml_fifo_fwft_rd_stage_pkg;

   localparam int c_RD_LAT_MIN = 1;
   localparam int c_RD_LAT_MAX = 3;
   localparam int c_IF_W       = 2;

   function automatic int f_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Buffer must absorb every in-flight read plus one for full throughput.
   function automatic bit f_cfg_ok(input int depth, input int lat);
      return (lat >= c_RD_LAT_MIN) && (lat <= c_RD_LAT_MAX) &&
             (depth >= lat + 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/ipml_fifo_fwft_rd_stage_buf.sv
// Ring buffer behind the FWFT read stage; head is always visible.
// Reset clears pointers and count only, storage keeps its contents.
module ipml_fifo_fwft_buf #(
   parameter int c_DATA_WIDTH = 16,
   parameter int c_BUF_DEPTH  = 4,
   parameter int c_BUF_AW     = 2
) (
   input  logic                    rclk,
   input  logic                    rrst,
   input  logic                    i_wr,
   input  logic [c_DATA_WIDTH-1:0] i_wdata,
   input  logic                    i_pop,
   output logic [c_DATA_WIDTH-1:0] o_head,
   output logic [c_BUF_AW:0]       o_cnt
);

   logic [c_DATA_WIDTH-1:0] r_mem [0:c_BUF_DEPTH-1];
   logic [c_BUF_AW-1:0]     r_wr_ptr;
   logic [c_BUF_AW-1:0]     r_rd_ptr;
   logic [c_BUF_AW:0]       r_cnt;
   logic                    w_pop;

   assign w_pop  = i_pop && (r_cnt != '0);
   assign o_head = r_mem[r_rd_ptr];
   assign o_cnt  = r_cnt;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (i_wr)  r_wr_ptr <= r_wr_ptr + c_BUF_AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + c_BUF_AW'(1);
         case ({i_wr, w_pop})
            2'b10:   r_cnt <= r_cnt + (c_BUF_AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (c_BUF_AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge rclk) begin
      if (i_wr && !rrst) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/ipml_fifo_fwft_rd_stage.sv
// FWFT read stage: credit-limited reads from the FIFO controller,
// latency-matched capture into a small ring buffer, valid/ready out.
module ipml_fifo_fwft_rd_stage
   import ipml_fifo_fwft_rd_stage_pkg::*;
#(
   parameter int c_DATA_WIDTH = 16,
   parameter int c_RD_LATENCY = 2,
   parameter int c_BUF_DEPTH  = 4,
   parameter int c_BUF_AW     = f_log2(c_BUF_DEPTH)
) (
   input  logic                    rclk,
   input  logic                    rrst,
   input  logic                    fifo_rempty,
   output logic                    fifo_ren,
   input  logic [c_DATA_WIDTH-1:0] fifo_rdata,
   output logic [c_DATA_WIDTH-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic [c_BUF_AW:0]       buf_level
);

   localparam int c_SW = c_BUF_AW + 2;

   if (!f_cfg_ok(c_BUF_DEPTH, c_RD_LATENCY) ||
       (c_BUF_AW != f_log2(c_BUF_DEPTH))) begin : g_cfg_err
      $error("ipml_fifo_fwft_rd_stage: illegal buffer/latency config");
   end

   logic [c_RD_LATENCY-1:0] r_pipe;
   logic [c_IF_W-1:0]       r_if_cnt;
   logic [c_BUF_AW:0]       w_buf_cnt;
   logic [c_DATA_WIDTH-1:0] w_head;
   logic [c_SW-1:0]         w_credit;
   logic                    w_ren;
   logic                    w_land;
   logic                    w_valid;
   logic                    w_pop;

   // Credit counts words held plus words still on their way back.
   assign w_credit = c_SW'(w_buf_cnt) + c_SW'(r_if_cnt);
   assign w_ren    = !rrst && !fifo_rempty &&
                     (w_credit < c_SW'(c_BUF_DEPTH));
   assign w_land   = r_pipe[c_RD_LATENCY-1];
   assign w_valid  = (w_buf_cnt != '0);
   assign w_pop    = w_valid && dout_ready;

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_pipe   <= '0;
         r_if_cnt <= '0;
      end else begin
         r_pipe[0] <= w_ren;
         for (int i = 1; i < c_RD_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
         case ({w_ren, w_land})
            2'b10:   r_if_cnt <= r_if_cnt + c_IF_W'(1);
            2'b01:   r_if_cnt <= r_if_cnt - c_IF_W'(1);
            default: r_if_cnt <= r_if_cnt;
         endcase
      end
   end

   always_ff @(posedge rclk) begin
      if (!rrst) begin
         assert (w_credit <= c_SW'(c_BUF_DEPTH));
      end
   end

   ipml_fifo_fwft_buf #(
      .c_DATA_WIDTH (c_DATA_WIDTH),
      .c_BUF_DEPTH  (c_BUF_DEPTH),
      .c_BUF_AW     (c_BUF_AW)
   ) u_buf (
      .rclk    (rclk),
      .rrst    (rrst),
      .i_wr    (w_land),
      .i_wdata (fifo_rdata),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_cnt   (w_buf_cnt)
   );

   assign fifo_ren   = w_ren;
   assign dout_valid = w_valid;
   assign dout       = w_valid ? w_head : '0;
   assign buf_level  = w_buf_cnt;

endmodule

// File: tb/tb_ipml_fifo_fwft_rd_stage.sv
// Directed bench for ipml_fifo_fwft_rd_stage with a FIFO/memory model
// and an in-order scoreboard on the output stream.
module tb_ipml_fifo_fwft_rd_stage;

   logic        rclk        = 1'b0;
   logic        rrst        = 1'b1;
   logic        fifo_rempty = 1'b1;
   logic        fifo_ren;
   logic [15:0] fifo_rdata;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready  = 1'b0;
   logic [2:0]  buf_level;

   int errors = 0;
   int checks = 0;

   logic [15:0] fq[$];
   logic [15:0] exp_q[$];
   bit          hold_empty = 1'b1;
   logic [15:0] d0 = 16'hDEAD;
   logic [15:0] d1 = 16'hDEAD;
   logic [15:0] m_w;

   assign fifo_rdata = d1;

   always #5 rclk = ~rclk;

   ipml_fifo_fwft_rd_stage dut (
      .rclk        (rclk),
      .rrst        (rrst),
      .fifo_rempty (fifo_rempty),
      .fifo_ren    (fifo_ren),
      .fifo_rdata  (fifo_rdata),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .buf_level   (buf_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   // FIFO controller + memory with 2-cycle read latency
   always @(posedge rclk) begin
      m_w = 16'hDEAD;
      if (fifo_ren) begin
         chk("ren_nonempty", 32'(fq.size() != 0), 32'd1);
         if (fq.size() != 0) m_w = fq.pop_front();
      end
      d1 <= d0;
      d0 <= m_w;
      #2 fifo_rempty = hold_empty || (fq.size() == 0);
   end

   always @(negedge rclk) begin
      if (!rrst && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 32'(dout), 32'hFFFFFFFF);
         else chk("sb_data", 32'(dout), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rrst = 1'b1;
      repeat (3) tick();
      rrst = 1'b0;

      // idle with FIFO empty
      for (int i = 0; i < 10; i++) begin
         @(negedge rclk);
         chk("idle_ren", 32'(fifo_ren), 0);
         chk("idle_valid", 32'(dout_valid), 0);
         chk("idle_level", 32'(buf_level), 0);
         chk("idle_dout", 32'(dout), 0);
      end

      // single word latency
      tick();
      fq.push_back(16'h00A5);
      exp_q.push_back(16'h00A5);
      dout_ready = 1'b1;
      hold_empty = 1'b0;
      @(negedge rclk); chk("one_ren_t0", 32'(fifo_ren), 1);
      @(negedge rclk); chk("one_ren_t1", 32'(fifo_ren), 0);
      @(negedge rclk); chk("one_valid_t2", 32'(dout_valid), 0);
      @(negedge rclk); chk("one_valid_t3", 32'(dout_valid), 1);
      chk("one_dout_t3", 32'(dout), 32'h00A5);
      @(negedge rclk); chk("one_valid_t4", 32'(dout_valid), 0);
      chk("one_level_t4", 32'(buf_level), 0);

      // 64-word burst, no gaps
      tick();
      for (int i = 0; i < 64; i++) begin
         fq.push_back(16'(i));
         exp_q.push_back(16'(i));
      end
      n = 0;
      @(negedge rclk);
      while (!dout_valid && n < 20) begin
         @(negedge rclk);
         n++;
      end
      chk("burst_start", 32'(dout_valid), 1);
      for (int i = 0; i < 64; i++) begin
         chk("burst_valid", 32'(dout_valid), 1);
         chk("burst_dout", 32'(dout), 32'(i));
         @(negedge rclk);
      end
      chk("burst_end_valid", 32'(dout_valid), 0);
      chk("burst_sb_empty", 32'(exp_q.size()), 0);

      // backpressure
      tick();
      dout_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         fq.push_back(16'h0100 + 16'(i));
         exp_q.push_back(16'h0100 + 16'(i));
      end
      repeat (10) @(negedge rclk);
      chk("bp_level", 32'(buf_level), 4);
      chk("bp_ren", 32'(fifo_ren), 0);
      chk("bp_valid", 32'(dout_valid), 1);
      chk("bp_dout", 32'(dout), 32'h0100);
      repeat (3) @(negedge rclk);
      chk("bp_hold_dout", 32'(dout), 32'h0100);
      chk("bp_hold_level", 32'(buf_level), 4);
      tick();
      dout_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge rclk);
         n++;
      end
      chk("bp_drained", 32'(exp_q.size()), 0);
      @(negedge rclk);
      chk("bp_end_valid", 32'(dout_valid), 0);

      // FIFO empties with two reads in flight
      tick();
      fq.push_back(16'h0010);
      fq.push_back(16'h0011);
      exp_q.push_back(16'h0010);
      exp_q.push_back(16'h0011);
      @(negedge rclk); chk("fl_ren_t0", 32'(fifo_ren), 1);
      @(negedge rclk); chk("fl_ren_t1", 32'(fifo_ren), 1);
      @(negedge rclk); chk("fl_ren_t2", 32'(fifo_ren), 0);
      chk("fl_valid_t2", 32'(dout_valid), 0);
      @(negedge rclk); chk("fl_dout_t3", 32'(dout), 32'h0010);
      @(negedge rclk); chk("fl_dout_t4", 32'(dout), 32'h0011);
      @(negedge rclk); chk("fl_valid_t5", 32'(dout_valid), 0);

      // reset with words buffered and in flight
      tick();
      dout_ready = 1'b0;
      for (int i = 0; i < 5; i++) fq.push_back(16'h0030 + 16'(i));
      n = 0;
      @(negedge rclk);
      while (buf_level != 3'd2 && n < 20) begin
         @(negedge rclk);
         n++;
      end
      chk("rst_pre_level", 32'(buf_level), 2);
      tick();
      rrst = 1'b1;
      @(negedge rclk); chk("rst_ren", 32'(fifo_ren), 0);
      tick();
      rrst = 1'b0;
      exp_q = fq;
      @(negedge rclk);
      chk("rst_valid", 32'(dout_valid), 0);
      chk("rst_level", 32'(buf_level), 0);
      chk("rst_dout", 32'(dout), 0);
      repeat (5) @(negedge rclk);
      chk("rst_post_level", 32'(buf_level), 1);
      chk("rst_post_dout", 32'(dout), 32'h0034);
      tick();
      dout_ready = 1'b1;
      @(negedge rclk);
      @(negedge rclk);
      chk("rst_end_valid", 32'(dout_valid), 0);
      chk("rst_sb_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
